// File: rtl/fazyrv_rf_seq_if.sv
// Bundle between the register-file sequencer and its environment:
// request handshake, operand/result chunk stream and the dual-port register RAM.
interface fazyrv_rf_seq_if #(
  parameter int unsigned REGW      = 32,
  parameter int unsigned ADRW      = 5,
  parameter int unsigned CHUNKSIZE = 2
);
  logic                 start_i;
  logic [ADRW-1:0]      rs1_i;
  logic [ADRW-1:0]      rs2_i;
  logic [ADRW-1:0]      rd_i;
  logic                 wb_i;
  logic                 busy_o;
  logic                 op_vld_o;
  logic [CHUNKSIZE-1:0] rs1_chunk_o;
  logic [CHUNKSIZE-1:0] rs2_chunk_o;
  logic [CHUNKSIZE-1:0] res_chunk_i;
  logic                 done_o;
  logic                 ram_we_o;
  logic [ADRW-1:0]      ram_waddr_o;
  logic [REGW-1:0]      ram_wdata_o;
  logic [ADRW-1:0]      ram_raddr_a_o;
  logic [REGW-1:0]      ram_rdata_a_i;
  logic [ADRW-1:0]      ram_raddr_b_o;
  logic [REGW-1:0]      ram_rdata_b_i;

  // The sequencer initiates all RAM traffic.
  modport master (
    input  start_i, rs1_i, rs2_i, rd_i, wb_i, res_chunk_i, ram_rdata_a_i, ram_rdata_b_i,
    output busy_o, op_vld_o, rs1_chunk_o, rs2_chunk_o, done_o,
    output ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_a_o, ram_raddr_b_o
  );

  modport slave (
    output start_i, rs1_i, rs2_i, rd_i, wb_i, res_chunk_i, ram_rdata_a_i, ram_rdata_b_i,
    input  busy_o, op_vld_o, rs1_chunk_o, rs2_chunk_o, done_o,
    input  ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_a_o, ram_raddr_b_o
  );
endinterface

// File: rtl/fazyrv_rf_seq.sv
// Register-file access sequencer: reads rs1/rs2, streams them LSB-first in chunks,
// collects the ALU result chunks and writes the assembled word back to rd.
module fazyrv_rf_seq #(
  parameter int unsigned REGW      = 32,
  parameter int unsigned ADRW      = 5,
  parameter int unsigned CHUNKSIZE = 2
) (
  input logic                clk_i,
  input logic                rst_in,
  fazyrv_rf_seq_if.master    bus
);

  localparam int unsigned N    = REGW / CHUNKSIZE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StLoad, StShift, StWrite} state_e;

  state_e          state_q, state_d;
  logic [ADRW-1:0] rs1_q, rs1_d;
  logic [ADRW-1:0] rs2_q, rs2_d;
  logic [ADRW-1:0] rd_q, rd_d;
  logic            wb_q, wb_d;
  logic [REGW-1:0] op1_q, op1_d;
  logic [REGW-1:0] op2_q, op2_d;
  logic [REGW-1:0] res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          rs1_d   = bus.rs1_i;
          rs2_d   = bus.rs2_i;
          rd_d    = bus.rd_i;
          wb_d    = bus.wb_i;
          state_d = StRead;
        end
      end
      StRead: state_d = StLoad;
      StLoad: begin
        op1_d   = bus.ram_rdata_a_i;
        op2_d   = bus.ram_rdata_b_i;
        res_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        op1_d = op1_q >> CHUNKSIZE;
        op2_d = op2_q >> CHUNKSIZE;
        // Result fills from the top so the first chunk ends up in the LSBs.
        res_d = {bus.res_chunk_i, res_q[REGW-1:CHUNKSIZE]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) state_d = StWrite;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy_o        = (state_q != StIdle);
  assign bus.op_vld_o      = (state_q == StShift);
  assign bus.rs1_chunk_o   = op1_q[CHUNKSIZE-1:0];
  assign bus.rs2_chunk_o   = op2_q[CHUNKSIZE-1:0];
  assign bus.done_o        = (state_q == StWrite);
  // x0 is hardwired to zero and must never be written.
  assign bus.ram_we_o      = (state_q == StWrite) && wb_q && (rd_q != '0);
  assign bus.ram_waddr_o   = rd_q;
  assign bus.ram_wdata_o   = res_q;
  assign bus.ram_raddr_a_o = rs1_q;
  assign bus.ram_raddr_b_o = rs2_q;

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Directed bench for fazyrv_rf_seq: a CHUNKSIZE=2 instance driven from a vector table
// plus hand sequences, and a CHUNKSIZE=1 instance for the long-stream variant.
module tb_fazyrv_rf_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fazyrv_rf_seq_if #(.REGW(32), .ADRW(5), .CHUNKSIZE(2)) ifa ();
  fazyrv_rf_seq_if #(.REGW(32), .ADRW(5), .CHUNKSIZE(1)) ifb ();

  fazyrv_rf_seq #(.REGW(32), .ADRW(5), .CHUNKSIZE(2)) dut_a (
    .clk_i (clk),
    .rst_in(rst_n),
    .bus   (ifa)
  );

  fazyrv_rf_seq #(.REGW(32), .ADRW(5), .CHUNKSIZE(1)) dut_b (
    .clk_i (clk),
    .rst_in(rst_n),
    .bus   (ifb)
  );

  // Register RAM models: one-cycle read latency, write on the rising edge.
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  int we_cnt_a = 0;

  always @(posedge clk) begin
    if (ifa.ram_we_o) begin
      mem_a[ifa.ram_waddr_o] <= ifa.ram_wdata_o;
      we_cnt_a <= we_cnt_a + 1;
    end
    ifa.ram_rdata_a_i <= mem_a[ifa.ram_raddr_a_o];
    ifa.ram_rdata_b_i <= mem_a[ifa.ram_raddr_b_o];
  end

  always @(posedge clk) begin
    if (ifb.ram_we_o) mem_b[ifb.ram_waddr_o] <= ifb.ram_wdata_o;
    ifb.ram_rdata_a_i <= mem_b[ifb.ram_raddr_a_o];
    ifb.ram_rdata_b_i <= mem_b[ifb.ram_raddr_b_o];
  end

  // ALU stand-in: result chunk is rs1 ^ rs2.
  assign ifa.res_chunk_i = ifa.rs1_chunk_o ^ ifa.rs2_chunk_o;
  assign ifb.res_chunk_i = ifb.rs1_chunk_o ^ ifb.rs2_chunk_o;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb;
    logic        mid_start;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic        exp_we;
    logic [31:0] exp_res;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [7];

  // Issue one request on instance A; sample on negedges, index 0 is the READ cycle.
  task automatic run_a(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wb, input logic mid, output int nvld,
                       output logic [1:0] c1, output logic [1:0] c2, output int didx,
                       output logic we, output logic [4:0] wa, output logic [31:0] wd);
    @(negedge clk);
    ifa.start_i = 1'b1;
    ifa.rs1_i   = rs1;
    ifa.rs2_i   = rs2;
    ifa.rd_i    = rd;
    ifa.wb_i    = wb;
    @(posedge clk);
    #1 ifa.start_i = 1'b0;
    nvld = 0; didx = -1; c1 = '0; c2 = '0; we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < 100 && didx < 0; i++) begin
      @(negedge clk);
      if (mid && i == 6) begin
        ifa.start_i = 1'b1;
        ifa.rs1_i   = 5'd1;
        ifa.rs2_i   = 5'd2;
        ifa.rd_i    = 5'd12;
        ifa.wb_i    = 1'b1;
      end
      if (mid && i == 7) ifa.start_i = 1'b0;
      if (ifa.op_vld_o) begin
        if (nvld == 0) begin
          c1 = ifa.rs1_chunk_o;
          c2 = ifa.rs2_chunk_o;
        end
        nvld++;
      end
      if (ifa.done_o) begin
        didx = i;
        we   = ifa.ram_we_o;
        wa   = ifa.ram_waddr_o;
        wd   = ifa.ram_wdata_o;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int nvld, didx, ndone;
    logic [1:0] c1, c2;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;

    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[1]  = 32'hFFFF_FFFF;
    mem_a[2]  = 32'h0F0F_0F0F;
    mem_a[5]  = 32'hDEAD_BEEF;
    mem_a[6]  = 32'h1234_5678;
    mem_a[9]  = 32'hA5A5_A5A5;
    mem_a[11] = 32'h0000_0001;
    mem_a[13] = 32'h1313_1313;
    mem_b[5]  = 32'hDEAD_BEEF;
    mem_b[6]  = 32'h1234_5678;

    ifa.start_i = 1'b0; ifa.rs1_i = '0; ifa.rs2_i = '0; ifa.rd_i = '0; ifa.wb_i = 1'b0;
    ifb.start_i = 1'b0; ifb.rs1_i = '0; ifb.rs2_i = '0; ifb.rd_i = '0; ifb.wb_i = 1'b0;

    //               rs1    rs2    rd      wb    mid   c1     c2     we    result         mem[rd]
    vecs[0] = '{5'd5,  5'd6,  5'd7,  1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 32'hCC99_E897, 32'hCC99_E897};
    vecs[1] = '{5'd1,  5'd2,  5'd8,  1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
    vecs[2] = '{5'd5,  5'd6,  5'd0,  1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'hCC99_E897, 32'h0000_0000};
    vecs[3] = '{5'd6,  5'd0,  5'd9,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h1234_5678, 32'hA5A5_A5A5};
    vecs[4] = '{5'd7,  5'd1,  5'd10, 1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 32'h3366_1768, 32'h3366_1768};
    vecs[5] = '{5'd11, 5'd0,  5'd3,  1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h0000_0001, 32'h0000_0001};
    vecs[6] = '{5'd3,  5'd0,  5'd4,  1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h0000_0001, 32'h0000_0001};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(ifa.busy_o),        32'h0);
    check("rst_op_vld", 32'(ifa.op_vld_o),      32'h0);
    check("rst_done",   32'(ifa.done_o),        32'h0);
    check("rst_we",     32'(ifa.ram_we_o),      32'h0);
    check("rst_raddr",  32'(ifa.ram_raddr_b_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy",  32'(ifa.busy_o),        32'h0);

    // Reset asserted mid-SHIFT abandons the request
    @(negedge clk);
    ifa.start_i = 1'b1; ifa.rs1_i = 5'd5; ifa.rs2_i = 5'd6; ifa.rd_i = 5'd13; ifa.wb_i = 1'b1;
    @(posedge clk);
    #1 ifa.start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_op_vld", 32'(ifa.op_vld_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(ifa.busy_o),        32'h0);
    check("midrst_op_vld", 32'(ifa.op_vld_o),      32'h0);
    check("midrst_done",   32'(ifa.done_o),        32'h0);
    check("midrst_we",     32'(ifa.ram_we_o),      32'h0);
    check("midrst_raddr",  32'(ifa.ram_raddr_a_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("postrst_busy",  32'(ifa.busy_o), 32'h0);
    check("postrst_no_we", 32'(we_cnt_a),   32'h0);
    check("postrst_x13",   mem_a[13],       32'h1313_1313);

    // Table-driven requests, issued back-to-back
    for (int v = 0; v < 7; v++) begin
      run_a(vecs[v].rs1, vecs[v].rs2, vecs[v].rd, vecs[v].wb, vecs[v].mid_start,
            nvld, c1, c2, didx, we, wa, wd);
      check($sformatf("v%0d_nvld", v),  32'(nvld), 32'd16);
      check($sformatf("v%0d_c1", v),    32'(c1),   32'(vecs[v].c1));
      check($sformatf("v%0d_c2", v),    32'(c2),   32'(vecs[v].c2));
      check($sformatf("v%0d_done_idx", v), 32'(didx), 32'd18);
      check($sformatf("v%0d_we", v),    32'(we),   32'(vecs[v].exp_we));
      check($sformatf("v%0d_waddr", v), 32'(wa),   32'(vecs[v].rd));
      check($sformatf("v%0d_wdata", v), wd,        vecs[v].exp_res);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_mem", v), mem_a[vecs[v].rd], vecs[v].exp_mem);
    end
    check("x12_untouched", mem_a[12], 32'h0);

    // No stray done pulses once idle
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ifa.done_o) ndone++;
    end
    check("idle_no_done", 32'(ndone), 32'h0);
    check("idle_busy_end", 32'(ifa.busy_o), 32'h0);

    // CHUNKSIZE=1 instance: 32 chunk cycles, done 34 samples after READ
    @(negedge clk);
    ifb.start_i = 1'b1; ifb.rs1_i = 5'd5; ifb.rs2_i = 5'd6; ifb.rd_i = 5'd7; ifb.wb_i = 1'b1;
    @(posedge clk);
    #1 ifb.start_i = 1'b0;
    nvld = 0; didx = -1; c1 = '0; c2 = '0; we = 1'b0; wd = '0;
    for (int i = 0; i < 100 && didx < 0; i++) begin
      @(negedge clk);
      if (ifb.op_vld_o) begin
        if (nvld == 0) begin
          c1 = {1'b0, ifb.rs1_chunk_o};
          c2 = {1'b0, ifb.rs2_chunk_o};
        end
        nvld++;
      end
      if (ifb.done_o) begin
        didx = i;
        we   = ifb.ram_we_o;
        wd   = ifb.ram_wdata_o;
      end
    end
    check("cs1_nvld",     32'(nvld), 32'd32);
    check("cs1_c1",       32'(c1),   32'd1);
    check("cs1_c2",       32'(c2),   32'd0);
    check("cs1_done_idx", 32'(didx), 32'd34);
    check("cs1_we",       32'(we),   32'd1);
    check("cs1_wdata",    wd,        32'hCC99_E897);
    @(posedge clk);
    #1;
    check("cs1_mem",      mem_b[7],  32'hCC99_E897);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fazyrv_rf_seq.md
Name: fazyrv_rf_seq

Overview:
Register-file access sequencer for the chunked (bit-serial) FazyRV datapath. It is the initiator side of the dual-port register RAM (two synchronous read ports, one write port, and reads suppressed while a write is in progress). Per request, the block:
- reads rs1 and rs2,
- streams both operands out LSB-first in CHUNKSIZE-bit chunks,
- collects the result chunks from the ALU,
- writes the assembled word back to rd.

Parameters:
REGW, 32, register width in bits
ADRW, 5, register address width
CHUNKSIZE, 2, bits per streamed chunk; legal values 1, 2, 4, 8; REGW % CHUNKSIZE == 0

Ports:
clk_i  in  1  clock, rising edge
rst_in  in  1  asynchronous reset, active-low
start_i  in  1  request strobe; accepted only in IDLE
rs1_i  in  ADRW  source register 1 address
rs2_i  in  ADRW  source register 2 address
rd_i  in  ADRW  destination register address
wb_i  in  1  write result back to rd
busy_o  out  1  high whenever state != IDLE
op_vld_o  out  1  operand chunks valid; result chunk sampled this cycle
rs1_chunk_o  out  CHUNKSIZE  current rs1 chunk (LSB-first)
rs2_chunk_o  out  CHUNKSIZE  current rs2 chunk (LSB-first)
res_chunk_i  in  CHUNKSIZE  result chunk from ALU, sampled when op_vld_o=1
done_o  out  1  one-cycle pulse, coincides with the write-back cycle
ram_we_o  out  1  RAM write enable
ram_waddr_o  out  ADRW  RAM write address
ram_wdata_o  out  REGW  RAM write data
ram_raddr_a_o  out  ADRW  RAM read address, port a
ram_rdata_a_i  in  REGW  RAM read data, port a (1-cycle latency)
ram_raddr_b_o  out  ADRW  RAM read address, port b
ram_rdata_b_i  in  REGW  RAM read data, port b (1-cycle latency)

Behaviour:
- Clocking and reset: single clock domain. rst_in low asynchronously forces:
  - state=IDLE, all shift registers and the chunk counter to 0;
  - busy_o, op_vld_o, done_o, ram_we_o = 0;
  - all address outputs = 0.
  Reset mid-operation abandons the request. No write occurs, including when reset is asserted during WRITE.
- Definitions: N = REGW/CHUNKSIZE. The chunk counter is clog2(N) bits wide.
- IDLE:
  - If start_i=1, latch rs1_i, rs2_i, rd_i and wb_i, then go to READ.
  - If start_i=0, stay in IDLE.
- READ (1 cycle):
  - ram_raddr_a_o = latched rs1, ram_raddr_b_o = latched rs2, ram_we_o=0.
  - Go to LOAD.
- LOAD (1 cycle):
  - Capture ram_rdata_a_i into the op1 shift register and ram_rdata_b_i into op2. Clear the result register and counter.
  - Go to SHIFT.
- SHIFT (N cycles):
  - op_vld_o=1. rs1_chunk_o / rs2_chunk_o = op1/op2 [CHUNKSIZE-1:0].
  - At each edge: op1 and op2 shift right by CHUNKSIZE. The result register shifts right by CHUNKSIZE with res_chunk_i entering at [REGW-1:REGW-CHUNKSIZE]. The counter increments.
  - When counter == N-1, go to WRITE.
- WRITE (1 cycle):
  - done_o=1.
  - ram_we_o = wb && (rd != 0). Register x0 is never written.
  - ram_waddr_o = rd, ram_wdata_o = result register.
  - Go to IDLE.
- Read-address outputs hold their latched values from READ until the next accepted start. ram_we_o is 0 in every state except WRITE, so reads are never blocked by the RAM.
- Latency: start accepted at edge t -> READ t+1, LOAD t+2, SHIFT t+3..t+2+N, WRITE/done_o at t+3+N. For the defaults (N=16), done_o is at t+19.
- The earliest next start is accepted in the IDLE cycle after WRITE; back-to-back throughput is N+4 cycles per request.
- start_i while busy_o=1 is ignored; it is not queued.
- A write in request k is visible to reads in request k+1, because READ follows WRITE by at least one edge.
- Outputs op_vld_o, done_o and ram_we_o are registered-state decodes. There are no combinational paths from inputs to outputs other than through state.

Test Plan:
- Reset then idle: with rst_in=0 mid-SHIFT -> busy_o, op_vld_o, ram_we_o and done_o go to 0 immediately. After release, state is IDLE and no write was issued.
- Pass-through:
  - Setup: preload RAM x5=0xDEADBEEF, x6=0x12345678. start rs1=5, rs2=6, rd=7, wb=1. The bench echoes res_chunk_i = rs1_chunk_o ^ rs2_chunk_o.
  - Required: 16 op_vld_o cycles. First chunks are rs1=2'b11, rs2=2'b00. done_o at t+19 with ram_we_o=1, waddr=7, wdata=0xCC99E897.
- x0 protection: rd=0, wb=1 -> done_o pulses, ram_we_o stays 0, and RAM x0 remains 0.
- No write-back: wb=0, rd=9 -> done_o pulses, ram_we_o=0, x9 unchanged.
- Start while busy: pulse start_i during SHIFT with different addresses -> ignored. The current request completes with its original rd, and exactly one done_o pulse.
- Back-to-back dependency: request A writes x3=0x00000001. Request B, started in the IDLE cycle after A's WRITE, reads rs1=3 -> B's LOAD captures 0x00000001. CHUNKSIZE=1 variant: 32 op_vld_o cycles, done_o at t+35.
